acumulador_sumas: RTL and testbench
===================================

// Module: acumulador_sumas
// PURPOSE
//  Downstream stage of the selective adder. Accepts a stream of NB_DATA-bit sums via valid/ready.
//  Accumulates frames of N_SAMPLES sums into a saturating accumulator and tracks the frame maximum.
//  Presents the frame result with an output valid/ready handshake.
//  Sits between the selective adder output and the result consumer (display/UART stage).
// PARAMETERS
//  NB_DATA    4  width of incoming sum (adder output width)
//  N_SAMPLES  8  sums per frame, >=2
//  NB_COUNT   3  sample counter width, must hold N_SAMPLES-1
//  NB_ACC     7  accumulator width; saturates at 2^NB_ACC-1
// PORTS
//  clock      in   1         single clock, rising edge
//  i_rst_n    in   1         asynchronous, active-low reset
//  i_suma     in   NB_DATA   incoming sum
//  i_valid    in   1         i_suma valid
//  o_ready    out  1         stage can accept a sample this cycle
//  i_clear    in   1         synchronous frame abort/clear
//  o_acc      out  NB_ACC    running / final frame sum
//  o_max      out  NB_DATA   running / final frame maximum
//  o_sat      out  1         sticky: accumulator saturated in this frame
//  o_valid    out  1         frame result valid
//  i_ready    in   1         consumer takes result
// BEHAVIOUR
//  - Reset (i_rst_n=0, async): state=ST_ACCUM; count=0, o_acc=0, o_max=0, o_sat=0, o_valid=0, o_ready=1.
//  - FSM states: ST_ACCUM (collecting), ST_HOLD (result held). State is registered; o_ready=(state==ST_ACCUM); o_valid=(state==ST_HOLD).
//  - Accept = i_valid & o_ready. Each accept, on the next edge:
//    o_acc<=sat(o_acc+i_suma), o_max<=max(o_max,i_suma), count<=count+1.
//  - Saturating add is computed at NB_ACC+1 bits. If the carry is set, o_acc<=all ones and o_sat<=1.
//    o_sat stays set until the frame is cleared.
//  - Accept with count==N_SAMPLES-1: count<=0, state<=ST_HOLD. Latency: the result is valid the cycle after the last accepted sample.
//  - ST_HOLD: o_acc/o_max/o_sat are frozen; i_valid is ignored (not accepted).
//    On i_ready=1: o_acc<=0, o_max<=0, o_sat<=0, state<=ST_ACCUM.
//    A new sample is accepted no earlier than the cycle after the handshake, so there is one bubble per frame.
//  - o_acc/o_max show running values during ST_ACCUM. The consumer must qualify them with o_valid.
//  - i_clear=1 (sync) has priority over accept and over the output handshake in any state.
//    Next edge: count=0, o_acc=0, o_max=0, o_sat=0, state=ST_ACCUM. A sample presented in the same cycle is discarded.
//  - i_clear together with i_ready in ST_HOLD: the clear wins; the frame counts as discarded.
//  - Reset mid-frame or mid-hold: immediate return to the reset values; the partial frame is lost.
//  - i_suma is treated as unsigned. No wrap-around ever occurs on o_acc.
//    count wraps only through the terminal-sample rule above.
// STRUCTURE
//  - Shared package/header holds:
//    - state localparams ST_ACCUM=1'b0, ST_HOLD=1'b1;
//    - default widths NB_DATA/NB_ACC, shared with the selective adder.
//  - One sub-module: sumador_saturado (NB_IN, NB_ACC). It is purely combinational: outputs sum and sat flag.
//  - Top holds the FSM, the counter, the max register and the handshake logic.
// TESTING
//  1. Reset release, then 8 accepts of i_suma=4'd3 with i_ready=0.
//     -> o_valid=1 the cycle after the 8th accept; o_acc=24, o_max=3, o_sat=0, o_ready=0.
//  2. Sequence 1,9,2,15,0,7,7,4, then i_ready=1 for 1 cycle.
//     -> o_acc=45, o_max=15. Next cycle: o_valid=0, o_acc=0, o_ready=1.
//  3. NB_ACC=6 instance with 8 samples of 4'd15.
//     -> after the 5th sample o_acc=63 and o_sat=1. Final o_acc=63, o_sat=1, o_max=15.
//  4. 3 accepts of 4'd5, then i_clear=1 with i_valid=1 and i_suma=4'd9.
//     -> next cycle o_acc=0, count=0. A full 8-sample frame of 4'd1 then yields o_acc=8.
//  5. In ST_HOLD: i_valid=1 for 4 cycles with i_ready=0.
//     -> no accept, o_acc stays frozen. Then i_clear=1 and i_ready=1 together -> cleared, ST_ACCUM.
//  6. i_rst_n dropped asynchronously between edges, mid-frame after 5 samples.
//     -> outputs go to the reset values immediately, without waiting for a clock edge.
//     After release, a full frame of 4'd2 yields o_acc=16.

Source files
------------

// File: rtl/acumulador_sumas_pkg.sv
// Shared definitions for the selective-adder result stage: FSM states and
// default widths common with the upstream adder.
package acumulador_sumas_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam int unsigned NB_DATA_DEF   = 4;
  localparam int unsigned NB_ACC_DEF    = 7;
  localparam int unsigned N_SAMPLES_DEF = 8;
  localparam int unsigned NB_COUNT_DEF  = 3;

endpackage

// File: rtl/acumulador_sumas_sumador_saturado.sv
// Combinational saturating adder: acc + unsigned input, clamped to all ones.
module sumador_saturado
  import acumulador_sumas_pkg::*;
#(
  parameter int unsigned NB_IN  = NB_DATA_DEF,
  parameter int unsigned NB_ACC = NB_ACC_DEF
) (
  input  logic [NB_ACC-1:0] i_acc,
  input  logic [NB_IN-1:0]  i_in,
  output logic [NB_ACC-1:0] o_sum,
  output logic              o_sat
);

  logic [NB_ACC:0] wide;

  always_comb begin
    wide  = {1'b0, i_acc} + {{(NB_ACC + 1 - NB_IN){1'b0}}, i_in};
    o_sat = wide[NB_ACC];
    o_sum = wide[NB_ACC] ? '1 : wide[NB_ACC-1:0];
  end

endmodule

// File: rtl/acumulador_sumas.sv
// Frame accumulator: sums N_SAMPLES incoming values with saturation, tracks
// the frame maximum and holds the result until the consumer takes it.
module acumulador_sumas
  import acumulador_sumas_pkg::*;
#(
  parameter int unsigned NB_DATA   = NB_DATA_DEF,
  parameter int unsigned N_SAMPLES = N_SAMPLES_DEF,
  parameter int unsigned NB_COUNT  = NB_COUNT_DEF,
  parameter int unsigned NB_ACC    = NB_ACC_DEF
) (
  input  logic               clock,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_suma,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_clear,
  output logic [NB_ACC-1:0]  o_acc,
  output logic [NB_DATA-1:0] o_max,
  output logic               o_sat,
  output logic               o_valid,
  input  logic               i_ready
);

  state_t              state_q, state_d;
  logic [NB_COUNT-1:0] count_q, count_d;
  logic [NB_ACC-1:0]   acc_q, acc_d;
  logic [NB_DATA-1:0]  max_q, max_d;
  logic                sat_q, sat_d;

  logic [NB_ACC-1:0]   sum;
  logic                sum_sat;

  sumador_saturado #(
    .NB_IN  (NB_DATA),
    .NB_ACC (NB_ACC)
  ) u_sumador (
    .i_acc (acc_q),
    .i_in  (i_suma),
    .o_sum (sum),
    .o_sat (sum_sat)
  );

  // Clear outranks both the sample accept and the output handshake.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    max_d   = max_q;
    sat_d   = sat_q;
    if (i_clear) begin
      state_d = ST_ACCUM;
      count_d = '0;
      acc_d   = '0;
      max_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (i_valid) begin
            acc_d = sum;
            max_d = (i_suma > max_q) ? i_suma : max_q;
            sat_d = sat_q | sum_sat;
            if (count_q == NB_COUNT'(N_SAMPLES - 1)) begin
              count_d = '0;
              state_d = ST_HOLD;
            end else begin
              count_d = count_q + NB_COUNT'(1);
            end
          end
        end
        ST_HOLD: begin
          if (i_ready) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            max_d   = '0;
            sat_d   = 1'b0;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_ACCUM;
      count_q <= '0;
      acc_q   <= '0;
      max_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      max_q   <= max_d;
      sat_q   <= sat_d;
    end
  end

  assign o_ready = (state_q == ST_ACCUM);
  assign o_valid = (state_q == ST_HOLD);
  assign o_acc   = acc_q;
  assign o_max   = max_q;
  assign o_sat   = sat_q;

endmodule

// File: tb/tb_acumulador_sumas.sv
// Bench for acumulador_sumas: two instances (7- and 6-bit accumulators) share
// one stimulus stream and are checked against a frame-list reference model.
module tb_acumulador_sumas;

  logic       clock = 1'b0;
  logic       i_rst_n;
  logic [3:0] i_suma;
  logic       i_valid, i_clear, i_ready;

  logic       ready7, sat7, valid7;
  logic [6:0] acc7;
  logic [3:0] max7;
  logic       ready6, sat6, valid6;
  logic [5:0] acc6;
  logic [3:0] max6;

  int n_vec = 0;
  int n_err = 0;

  // Model: samples of the current frame and whether the frame is being held.
  int q[$];
  bit hold;

  always #5 clock = ~clock;

  acumulador_sumas #(.NB_DATA(4), .N_SAMPLES(8), .NB_COUNT(3), .NB_ACC(7)) u7 (
    .clock(clock), .i_rst_n(i_rst_n), .i_suma(i_suma), .i_valid(i_valid),
    .o_ready(ready7), .i_clear(i_clear), .o_acc(acc7), .o_max(max7),
    .o_sat(sat7), .o_valid(valid7), .i_ready(i_ready)
  );

  acumulador_sumas #(.NB_DATA(4), .N_SAMPLES(8), .NB_COUNT(3), .NB_ACC(6)) u6 (
    .clock(clock), .i_rst_n(i_rst_n), .i_suma(i_suma), .i_valid(i_valid),
    .o_ready(ready6), .i_clear(i_clear), .o_acc(acc6), .o_max(max6),
    .o_sat(sat6), .o_valid(valid6), .i_ready(i_ready)
  );

  function automatic int total();
    int s = 0;
    foreach (q[k]) s += q[k];
    return s;
  endfunction

  function automatic int qmax();
    int m = 0;
    foreach (q[k]) if (q[k] > m) m = q[k];
    return m;
  endfunction

  function automatic int lim(int nb);
    return (1 << nb) - 1;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int t = total();
    chk("acc7",   int'(acc7),   (t > lim(7)) ? lim(7) : t);
    chk("sat7",   int'(sat7),   (t > lim(7)) ? 1 : 0);
    chk("max7",   int'(max7),   qmax());
    chk("valid7", int'(valid7), int'(hold));
    chk("ready7", int'(ready7), int'(!hold));
    chk("acc6",   int'(acc6),   (t > lim(6)) ? lim(6) : t);
    chk("sat6",   int'(sat6),   (t > lim(6)) ? 1 : 0);
    chk("max6",   int'(max6),   qmax());
    chk("valid6", int'(valid6), int'(hold));
    chk("ready6", int'(ready6), int'(!hold));
  endtask

  task automatic model_reset();
    q.delete();
    hold = 1'b0;
  endtask

  // Drive one cycle of inputs, step the model across the edge, check after it.
  task automatic cycle(input bit v, input int s, input bit c, input bit r);
    i_valid = v;
    i_suma  = 4'(s);
    i_clear = c;
    i_ready = r;
    @(posedge clock);
    if (c) model_reset();
    else if (hold) begin
      if (r) model_reset();
    end else if (v) begin
      q.push_back(s & 15);
      if (q.size() == 8) hold = 1'b1;
    end
    #1;
    check_all();
  endtask

  initial begin
    int seq2[8] = '{1, 9, 2, 15, 0, 7, 7, 4};
    i_rst_n = 1'b0;
    i_suma  = '0;
    i_valid = 1'b0;
    i_clear = 1'b0;
    i_ready = 1'b0;
    model_reset();
    #3;
    check_all();
    chk("rst_ready", int'(ready7), 1);
    @(negedge clock);
    i_rst_n = 1'b1;

    // Frame of eight 3s, consumer not ready
    for (int i = 0; i < 8; i++) cycle(1, 3, 0, 0);
    chk("t1_valid", int'(valid7), 1);
    chk("t1_acc",   int'(acc7), 24);
    chk("t1_max",   int'(max7), 3);
    chk("t1_ready", int'(ready7), 0);
    cycle(0, 0, 0, 1);

    for (int i = 0; i < 8; i++) cycle(1, seq2[i], 0, 0);
    chk("t2_acc", int'(acc7), 45);
    chk("t2_max", int'(max7), 15);
    cycle(0, 0, 0, 1);
    chk("t2_valid_after", int'(valid7), 0);
    chk("t2_acc_after",   int'(acc7), 0);
    chk("t2_ready_after", int'(ready7), 1);

    // Saturation on the 6-bit instance
    for (int i = 0; i < 5; i++) cycle(1, 15, 0, 0);
    chk("t3_acc6_5th", int'(acc6), 63);
    chk("t3_sat6_5th", int'(sat6), 1);
    chk("t3_acc7_5th", int'(acc7), 75);
    for (int i = 0; i < 3; i++) cycle(1, 15, 0, 0);
    chk("t3_acc6_fin", int'(acc6), 63);
    chk("t3_sat6_fin", int'(sat6), 1);
    chk("t3_max6_fin", int'(max6), 15);
    chk("t3_acc7_fin", int'(acc7), 120);
    chk("t3_sat7_fin", int'(sat7), 0);
    cycle(0, 0, 0, 1);

    // Clear mid-frame discards the concurrent sample
    for (int i = 0; i < 3; i++) cycle(1, 5, 0, 0);
    cycle(1, 9, 1, 0);
    chk("t4_acc_clr", int'(acc7), 0);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0);
    chk("t4_acc", int'(acc7), 8);
    chk("t4_valid", int'(valid7), 1);

    // Hold ignores i_valid; clear beats handshake
    for (int i = 0; i < 4; i++) cycle(1, 7, 0, 0);
    chk("t5_frozen", int'(acc7), 8);
    cycle(1, 7, 1, 1);
    chk("t5_ready", int'(ready7), 1);
    chk("t5_acc",   int'(acc7), 0);

    // Asynchronous reset between edges, mid-frame
    for (int i = 0; i < 5; i++) cycle(1, 2, 0, 0);
    #3;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("t6_rst_acc", int'(acc7), 0);
    #2;
    i_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1, 2, 0, 0);
    chk("t6_acc", int'(acc7), 16);
    chk("t6_valid", int'(valid7), 1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle(($urandom % 4) != 0, int'($urandom_range(0, 15)),
            ($urandom % 20) == 0, ($urandom % 3) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
